// File: rtl/scalar_fu_pkg.sv
// Shared types for the scalar FU issue front end: FU opcodes and issue FSM states.
package scalar_fu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SNA = 3'd1,
    MUL = 3'd2,
    LSH = 3'd3,
    RSH = 3'd4
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/scalar_rf.sv
// Local scalar register file: two asynchronous read ports, FU writeback plus an
// external load port that takes priority when both target the same entry.
module scalar_rf #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 8,
  parameter int RF_AW    = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [RF_AW-1:0]  rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [RF_AW-1:0]  rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [RF_AW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wb_en,
  input  logic [RF_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] mem [RF_DEPTH];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  // The external write is scheduled last so it overrides a same-address writeback.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wb_en) mem[wb_addr] <= wb_data;
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/scalar_fu_issue.sv
// Issue/sequencing front end for scalar_fu: accepts one instruction, holds FU
// inputs for the op latency, writes the result back and returns it.
module scalar_fu_issue
  import scalar_fu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 8,
  parameter int MUL_LAT  = 2,
  localparam int RF_AW   = $clog2(RF_DEPTH)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [RF_AW-1:0]  instr_rd,
  input  logic [RF_AW-1:0]  instr_rs1,
  input  logic [RF_AW-1:0]  instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              wr_en,
  input  logic [RF_AW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [2:0]        fu_aluop,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [DATA_W-1:0] fu_c,
  input  logic [DATA_W-1:0] fu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [RF_AW-1:0]  rsp_rd,
  output state_t            dbg_state
);

  state_t            state_q, state_next;
  logic [2:0]        op_q;
  logic [RF_AW-1:0]  rd_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [RF_AW-1:0]  rsp_rd_q;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              capture, wb_en, last_cycle;

  scalar_rf #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH), .RF_AW(RF_AW)) u_rf (
    .CLK       (CLK),
    .nRST      (nRST),
    .rd_addr_a (instr_rs1),
    .rd_data_a (rs1_data),
    .rd_addr_b (instr_rs2),
    .rd_data_b (rs2_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wb_en     (wb_en),
    .wb_addr   (rd_q),
    .wb_data   (fu_out)
  );

  // MUL is a multicycle path through the FU; every other opcode settles in one cycle.
  assign last_cycle = (op_q == MUL) ? (cnt_q == 3'(MUL_LAT - 1)) : (cnt_q == 3'd0);

  // Handshakes: a transfer happens on a rising edge where valid && ready; an
  // offered instruction may change only after it transfers, and rsp_data/rsp_rd
  // stay fixed while rsp_valid is high until the consumer takes them.
  always_comb begin
    state_next  = state_q;
    capture     = 1'b0;
    wb_en       = 1'b0;
    instr_ready = 1'b0;
    rsp_valid   = 1'b0;
    fu_aluop    = '0;
    fu_a        = '0;
    fu_b        = '0;
    fu_c        = '0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          capture    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        fu_aluop = op_q;
        fu_a     = a_q;
        fu_b     = b_q;
        fu_c     = imm_q;
        if (last_cycle) begin
          wb_en      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
    end else begin
      state_q <= state_next;
      if (capture) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        a_q   <= rs1_data;
        b_q   <= rs2_data;
        imm_q <= instr_imm;
        cnt_q <= '0;
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (wb_en) begin
        rsp_data_q <= fu_out;
        rsp_rd_q   <= rd_q;
      end
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_scalar_fu_issue.sv
// Bench for scalar_fu_issue: behavioural scalar_fu stand-in, transaction-level
// reference model with per-cycle compare, directed literal cases, random traffic.
module tb_scalar_fu_issue;
  import scalar_fu_pkg::*;

  localparam int DATA_W = 16;
  localparam int RF_DEPTH = 8;
  localparam int MUL_LAT = 2;
  localparam int RF_AW = 3;

  logic              CLK, nRST;
  logic              instr_valid, instr_ready;
  logic [2:0]        instr_op;
  logic [RF_AW-1:0]  instr_rd, instr_rs1, instr_rs2;
  logic [DATA_W-1:0] instr_imm;
  logic              wr_en;
  logic [RF_AW-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        fu_aluop;
  logic [DATA_W-1:0] fu_a, fu_b, fu_c, fu_out;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [RF_AW-1:0]  rsp_rd;
  state_t            dbg_state;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  scalar_fu_issue #(.DATA_W(DATA_W), .RF_DEPTH(RF_DEPTH), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .nRST(nRST),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fu_aluop(fu_aluop), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c), .fu_out(fu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .dbg_state(dbg_state)
  );

  // Behavioural scalar_fu: combinational result from the FU inputs.
  function automatic logic [DATA_W-1:0] fu_f(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    logic signed [DATA_W-1:0] sa;
    sa = a;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + (b << c);
      3'd2:    return a * b;
      3'd3:    return a << b;
      3'd4:    return DATA_W'(sa >>> b);
      default: return '0;
    endcase
  endfunction

  assign fu_out = fu_f(fu_aluop, fu_a, fu_b, fu_c);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, counted in edges since accept.
  logic [DATA_W-1:0] m_rf [RF_DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic              m_busy = 1'b0;
  int                m_n = 0;
  int                m_lat = 0;
  logic [2:0]        m_op = '0;
  logic [RF_AW-1:0]  m_rd = '0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0, m_imm = '0;
  logic [DATA_W-1:0] m_last_data = '0;
  logic [RF_AW-1:0]  m_last_rd = '0;

  task automatic model_step();
    if (!nRST) begin
      for (int i = 0; i < RF_DEPTH; i++) m_rf[i] = '0;
      exp_q.delete();
      m_busy = 1'b0; m_n = 0; m_op = '0; m_a = '0; m_b = '0; m_imm = '0;
      m_last_data = '0; m_last_rd = '0;
    end else begin
      if (m_busy) begin
        if (m_n >= m_lat) begin
          if (rsp_ready) m_busy = 1'b0;
        end else begin
          if (m_n == m_lat - 1) begin
            m_last_data = exp_q.pop_front();
            m_last_rd = m_rd;
            m_rf[m_rd] = m_last_data;
          end
          m_n++;
        end
      end else if (instr_valid) begin
        m_op = instr_op; m_rd = instr_rd; m_imm = instr_imm;
        m_a = m_rf[instr_rs1]; m_b = m_rf[instr_rs2];
        exp_q.push_back(fu_f(m_op, m_a, m_b, m_imm));
        m_lat = (instr_op == 3'd2) ? 1 + MUL_LAT : 2;
        m_busy = 1'b1; m_n = 1;
      end
      if (wr_en) m_rf[wr_addr] = wr_data;
    end
  endtask

  task automatic compare_step();
    logic exec;
    exec = m_busy && (m_n < m_lat);
    check("instr_ready", instr_ready, !m_busy);
    check("rsp_valid", rsp_valid, m_busy && (m_n >= m_lat));
    check("rsp_data", rsp_data, m_last_data);
    check("rsp_rd", rsp_rd, m_last_rd);
    check("fu_aluop", fu_aluop, exec ? m_op : 3'd0);
    check("fu_a", fu_a, exec ? m_a : '0);
    check("fu_b", fu_b, exec ? m_b : '0);
    check("fu_c", fu_c, exec ? m_imm : '0);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (cmp_en) compare_step();
  end

  task automatic load(input logic [RF_AW-1:0] addr, input logic [DATA_W-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  // wr_mode: 0 none, 1 external write to rs1 in the accept cycle, 2 external write to rd in the writeback cycle.
  task automatic run_op(input logic [2:0] op, input logic [RF_AW-1:0] rd, input logic [RF_AW-1:0] rs1,
                        input logic [RF_AW-1:0] rs2, input logic [DATA_W-1:0] imm,
                        input logic [DATA_W-1:0] exp_data, input int exp_lat, input int hold,
                        input int wr_mode, input logic [DATA_W-1:0] wr_val, input string tag);
    int n;
    logic [DATA_W-1:0] exp_mem;
    check({tag, "_ready"}, instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    if (wr_mode == 1) begin wr_en = 1'b1; wr_addr = rs1; wr_data = wr_val; end
    @(negedge CLK);
    instr_valid = 1'b0; wr_en = 1'b0;
    n = 1;
    if (wr_mode == 2) begin wr_en = 1'b1; wr_addr = rd; wr_data = wr_val; end
    while (!rsp_valid && n < 20) begin
      @(negedge CLK);
      wr_en = 1'b0;
      n++;
    end
    wr_en = 1'b0;
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_rd"}, rsp_rd, rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_ready"}, instr_ready, 0);
      check({tag, "_hold_data"}, rsp_data, exp_data);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    exp_mem = (wr_mode == 2) ? wr_val : exp_data;
    check({tag, "_rf"}, dut.u_rf.mem[rd], exp_mem);
  endtask

  initial begin
    nRST = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    instr_imm = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_state", dbg_state, IDLE);
    check("reset_ready", instr_ready, 1);
    check("reset_valid", rsp_valid, 0);
    check("reset_fu_a", fu_a, 0);
    check("reset_rsp_data", rsp_data, 0);
    nRST = 1'b1;
    cmp_en = 1'b1;

    load(3'd1, 16'd3);
    load(3'd2, 16'd5);
    run_op(3'd0, 3'd3, 3'd1, 3'd2, 16'd0, 16'd8,  2, 0, 0, 16'd0, "add");
    run_op(3'd1, 3'd6, 3'd1, 3'd2, 16'd2, 16'd23, 2, 0, 0, 16'd0, "sna");
    run_op(3'd2, 3'd7, 3'd1, 3'd2, 16'd0, 16'd15, 3, 0, 0, 16'd0, "mul");
    load(3'd4, 16'h8000);
    load(3'd5, 16'd1);
    run_op(3'd4, 3'd6, 3'd4, 3'd5, 16'd0, 16'hC000, 2, 0, 0, 16'd0, "rsh");
    load(3'd4, 16'h00FF);
    load(3'd5, 16'd4);
    run_op(3'd3, 3'd6, 3'd4, 3'd5, 16'd0, 16'h0FF0, 2, 0, 0, 16'd0, "lsh");
    load(3'd4, 16'h0100);
    run_op(3'd2, 3'd7, 3'd4, 3'd4, 16'd0, 16'h0000, 3, 0, 0, 16'd0, "mul_trunc");
    run_op(3'd0, 3'd0, 3'd1, 3'd2, 16'd0, 16'd8,  2, 5, 0, 16'd0, "stall");
    run_op(3'd0, 3'd5, 3'd0, 3'd1, 16'd0, 16'd11, 2, 0, 0, 16'd0, "b2b");
    run_op(3'd0, 3'd3, 3'd1, 3'd2, 16'd0, 16'd8,  2, 0, 2, 16'h1234, "wb_clash");
    run_op(3'd0, 3'd4, 3'd1, 3'd2, 16'd0, 16'd8,  2, 0, 1, 16'd100, "rs1_clash");
    check("rs1_clash_new", dut.u_rf.mem[1], 16'd100);
    run_op(3'd7, 3'd2, 3'd1, 3'd0, 16'd0, 16'd0,  2, 0, 0, 16'd0, "undef");

    // Reset during MUL EXEC aborts the op.
    instr_valid = 1'b1; instr_op = 3'd2; instr_rd = 3'd5; instr_rs1 = 3'd1; instr_rs2 = 3'd0;
    @(negedge CLK);
    instr_valid = 1'b0;
    check("abort_in_exec", fu_aluop, 3'd2);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    check("abort_ready", instr_ready, 1);
    check("abort_valid", rsp_valid, 0);
    check("abort_fu_aluop", fu_aluop, 0);
    check("abort_fu_a", fu_a, 0);
    for (int i = 0; i < RF_DEPTH; i++) check("abort_rf", dut.u_rf.mem[i], 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      nRST = ($urandom_range(0, 299) != 0);
      instr_valid = $urandom_range(0, 1);
      instr_op = 3'($urandom_range(0, 7));
      instr_rd = 3'($urandom_range(0, 7));
      instr_rs1 = 3'($urandom_range(0, 7));
      instr_rs2 = 3'($urandom_range(0, 7));
      instr_imm = 16'($urandom_range(0, 5));
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
    end
    @(negedge CLK);
    nRST = 1'b1; instr_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
    repeat (12) @(negedge CLK);
    check("drain_idle", instr_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
